// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: types shared by the instruction prefetch unit.
//   InstAddr / Inst : 32-bit instruction address and instruction word.
//   RV_NOP          : value shown on the instruction output when nothing is valid.
//   FetchQState     : prefetch FSM states.
//   FetchEntry      : one buffered {pc, inst} pair.
package fetch_queue_pkg;

  typedef logic [31:0] InstAddr;
  typedef logic [31:0] Inst;

  localparam Inst RV_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DRAIN
  } FetchQState;

  typedef struct packed {
    InstAddr pc;
    Inst     inst;
  } FetchEntry;

  function automatic InstAddr align_word(input InstAddr a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// fetch_fifo: circular buffer holding prefetched entries.
// Ports:
//   i_clock, i_reset (sync, active-low)
//   i_push / i_pushData : write one entry at the tail
//   i_pop               : advance the head (caller only pops when o_valid)
//   i_flush             : empty the buffer and zero both pointers
//   o_valid             : head entry present
//   o_headData          : head entry, read from registered storage
//   o_count             : number of stored entries (log2(DEPTH)+1 bits)
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_pushData,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic                     o_valid,
  output logic [WIDTH-1:0]         o_headData,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d = mem_q;
    if (i_push && !i_flush) begin
      mem_d[wr_ptr_q] = i_pushData;
    end
  end

  // Pointers are log2(DEPTH) bits wide and wrap on overflow.
  always_comb begin
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(i_push);
      rd_ptr_d = rd_ptr_q + PTR_W'(i_pop);
      count_d  = count_q + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  always_ff @(posedge i_clock) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign o_valid    = (count_q != '0);
  assign o_headData = mem_q[rd_ptr_q];
  assign o_count    = count_q;

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch unit between the instruction memory bus
// and the IF stage. Issues sequential word fetches, buffers {pc, inst} in a
// fetch_fifo, delivers one instruction per cycle, and on redirect flushes the
// buffer and discards any in-flight response.
// Ports:
//   i_clock, i_reset (sync, active-low)
//   o_memReq / o_memAddr / i_memAck / i_memData : instruction memory bus
//   i_redirect / i_redirectPc : flush and restart fetch at target
//   i_stall                   : consumer not accepting this cycle
//   o_valid / o_inst / o_pc   : FIFO head (NOP / 0 when empty)
//   o_perfRedirects, o_perfEmptyCycles : only when FETCHQ_PERF_EN is defined
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter InstAddr     RESET_PC = 32'h0
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic        o_memReq,
  output logic [31:0] o_memAddr,
  input  logic        i_memAck,
  input  logic [31:0] i_memData,
  input  logic        i_redirect,
  input  logic [31:0] i_redirectPc,
  input  logic        i_stall,
  output logic        o_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc
`ifdef FETCHQ_PERF_EN
  ,
  output logic [31:0] o_perfRedirects,
  output logic [31:0] o_perfEmptyCycles
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  FetchQState state_q, state_d;
  InstAddr    fetch_pc_q, fetch_pc_d;
  InstAddr    hold_addr_q, hold_addr_d;

  logic             push;
  logic             pop;
  logic             fifo_valid;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             space;
  FetchEntry        push_entry;
  FetchEntry        head;
  InstAddr          redirect_tgt;

  assign redirect_tgt = align_word(i_redirectPc);

  assign push = (state_q == BUSY) && i_memAck && !i_redirect;
  assign pop  = fifo_valid && !i_stall && !i_redirect;

  // Occupancy after this edge; a redirect empties the buffer outright.
  assign count_next = i_redirect ? '0 : (count + CNT_W'(push) - CNT_W'(pop));
  assign space      = (count_next < DEPTH_C);

  assign push_entry = '{pc: fetch_pc_q, inst: i_memData};

  fetch_fifo #(
    .DEPTH(DEPTH),
    .WIDTH($bits(FetchEntry))
  ) u_fifo (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_push    (push),
    .i_pushData(push_entry),
    .i_pop     (pop),
    .i_flush   (i_redirect),
    .o_valid   (fifo_valid),
    .o_headData(head),
    .o_count   (count)
  );

  // fetch_pc_q always tracks the next address to fetch (including a pending
  // redirect target); hold_addr_q keeps the abandoned request stable in DRAIN
  // until the bus acknowledges it.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    hold_addr_d = hold_addr_q;
    unique case (state_q)
      IDLE: begin
        if (i_redirect) begin
          fetch_pc_d = redirect_tgt;
          state_d    = BUSY;
        end else if (space) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (i_redirect) begin
          fetch_pc_d = redirect_tgt;
          if (!i_memAck) begin
            hold_addr_d = fetch_pc_q;
            state_d     = DRAIN;
          end
        end else if (i_memAck) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          if (!space) begin
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        if (i_redirect) begin
          fetch_pc_d = redirect_tgt;
        end
        if (i_memAck) begin
          state_d = BUSY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      hold_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      hold_addr_q <= hold_addr_d;
    end
  end

  assign o_memReq  = (state_q != IDLE);
  assign o_memAddr = (state_q == DRAIN) ? hold_addr_q : fetch_pc_q;

  assign o_valid = fifo_valid;
  assign o_inst  = fifo_valid ? head.inst : RV_NOP;
  assign o_pc    = fifo_valid ? head.pc : '0;

`ifdef FETCHQ_PERF_EN
  logic [31:0] perf_redirects_q, perf_redirects_d;
  logic [31:0] perf_empty_q, perf_empty_d;

  always_comb begin
    perf_redirects_d = perf_redirects_q + 32'(i_redirect);
    perf_empty_d     = perf_empty_q + 32'(!fifo_valid);
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      perf_redirects_q <= '0;
      perf_empty_q     <= '0;
    end else begin
      perf_redirects_q <= perf_redirects_d;
      perf_empty_q     <= perf_empty_d;
    end
  end

  assign o_perfRedirects   = perf_redirects_q;
  assign o_perfEmptyCycles = perf_empty_q;
`else
  // Performance counters not built.
`endif

endmodule
